mfp_bot_handshake: RTL and testbench
====================================

Name: mfp_bot_handshake

Overview:
Sits between the Rojobot and the mfp_sys memory-mapped I/O ports (IO_BotInfo, IO_BotUpdt_Sync, IO_INT_ACK), directly upstream of the CPU-side bot registers.
- Synchronizes the Rojobot update strobe and detects its rising edge.
- Snapshots bot info for each accepted update.
- Holds a sticky update flag until software acknowledges it.
- Buffers one update that arrives while the flag is held, and counts overruns.
- Flags acknowledge timeouts.

Parameters:
SYNC_STAGES, 2, flip-flops in the bot_upd_raw synchronizer (minimum 2).
TIMEOUT_CYCLES, 1000000, cycles spent in PENDING before ack_timeout sets (minimum 1).
MISS_W, 8, width of the saturating missed-update counter.

Ports:
HCLK  in  1  system clock; all logic on the rising edge.
SI_Reset  in  1  asynchronous, active-high reset.
bot_upd_raw  in  1  Rojobot update strobe, any width ≥1 cycle, may be asynchronous to HCLK.
bot_info_raw  in  32  Rojobot location/sensor word; stable ≥SYNC_STAGES+2 cycles after bot_upd_raw rises.
IO_INT_ACK  in  1  software acknowledge level, driven by a CPU register bit.
clr_stats  in  1  one-cycle pulse; clears miss_cnt, overrun and ack_timeout.
IO_BotUpdt_Sync  out  1  sticky update-pending flag to the CPU.
IO_BotInfo  out  32  bot info snapshot of the currently presented update.
upd_irq  out  1  one-cycle pulse on each IDLE→PENDING transition.
miss_cnt  out  MISS_W  overwritten-update count; saturates at all-ones.
overrun  out  1  sticky; set with any miss_cnt increment event.
ack_timeout  out  1  sticky; set when PENDING lasts TIMEOUT_CYCLES.

Behaviour:
- **Reset.** All outputs are 0, the FSM is in IDLE, the sync chain is 0, the queue is empty and the timer is 0. Reset asserted mid-operation drops every output to 0 immediately, with no clock required.
- **Sync and edge detect.**
  - sync[0..SYNC_STAGES-1] samples bot_upd_raw.
  - upd_evt = sync[last] & ~sync_d, where sync_d is sync[last] delayed one cycle.
  - If raw is high before edge k, upd_evt is high in the cycle after edge k+SYNC_STAGES−1.
  - In IDLE, IO_BotUpdt_Sync is visible after edge k+SYNC_STAGES.
- **FSM states: IDLE, PENDING, ACKED.**
  - IDLE, upd_evt or queue valid: go to PENDING.
    - Load IO_BotInfo from bot_info_raw on upd_evt, otherwise from the queue.
    - Set IO_BotUpdt_Sync=1, pulse upd_irq, clear the timer.
    - If upd_evt and the queue are both valid, the queue entry is presented and upd_evt goes into the queue.
  - PENDING, IO_INT_ACK=1: go to ACKED and set IO_BotUpdt_Sync=0 in the same edge.
  - ACKED, IO_INT_ACK=0: go to IDLE. A valid queue entry is promoted on the following edge (IDLE rule).
- **Queue (one entry: valid bit + 32-bit info).**
  - An upd_evt in PENDING or ACKED writes the queue.
  - If the queue was already valid, the entry is overwritten (newest wins), miss_cnt increments and overrun sets.
  - upd_evt in the same cycle that PENDING sees ack: the FSM still goes to ACKED and the event is queued normally.
- **Timer.** Counts in PENDING only, saturating at TIMEOUT_CYCLES. ack_timeout sets on the cycle the count reaches TIMEOUT_CYCLES−1. The timer clears on leaving PENDING; ack_timeout does not.
- **clr_stats.**
  - Clears miss_cnt, overrun and ack_timeout next edge.
  - If a miss event occurs in the same cycle, the counter loads 1 and overrun stays set (increment beats clear).
  - If a timeout occurs in the same cycle, ack_timeout stays set.
- **Widths.** miss_cnt is an unsigned MISS_W-bit count: no wrap, hold at 2^MISS_W−1. The timer width is $clog2(TIMEOUT_CYCLES+1).
- **IO_BotInfo** changes only on an IDLE→PENDING transition.

Decomposition:
- Shared package mfp_bot_pkg holds:
  - the FSM state encoding (IDLE=2'd0, PENDING=2'd1, ACKED=2'd2);
  - the default SYNC_STAGES, TIMEOUT_CYCLES and MISS_W constants.
- One sub-module: mfp_sync_edge (parameterized synchronizer plus rising-edge detector, output upd_evt). It is reusable for the push-button inputs.

Test Plan:
1. **Basic handshake.** Reset, then raise raw for 5 cycles with info=32'h1234_5678.
   - Sync=1 exactly SYNC_STAGES+1 edges later, IO_BotInfo=32'h1234_5678, one upd_irq pulse.
   - ACK=1 → Sync=0 next edge.
   - ACK=0 → IDLE; miss_cnt=0.
2. **Single queued update.** While PENDING, one update with info=32'hAAAA_0001.
   - After ACK 1→0, Sync reasserts one cycle after reaching IDLE.
   - IO_BotInfo=32'hAAAA_0001, second upd_irq, miss_cnt=0.
3. **Overwrite.** Three updates while PENDING (info 1, 2, 3).
   - miss_cnt=2, overrun=1.
   - After the ack cycle, the presented info is 3.
   - clr_stats → miss_cnt=0, overrun=0.
4. **Timeout.** TIMEOUT_CYCLES=16, update, no ack.
   - ack_timeout=1 after the 16th PENDING cycle, not before.
   - Ack → stays 1 until clr_stats.
5. **Saturation and simultaneity.**
   - MISS_W=2: 5 misses → miss_cnt=3.
   - Ack and upd_evt in the same cycle → ACKED and the event is queued.
   - clr_stats with a concurrent miss → miss_cnt=1.
6. **Reset mid-PENDING with a valid queue.**
   - All outputs are 0 asynchronously.
   - After release, no spurious Sync or upd_irq while raw is held high.

Source files
------------

// File: rtl/mfp_bot_pkg.sv
// Shared definitions for the Rojobot update handshake: FSM encoding and
// default build constants.
package mfp_bot_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACKED   = 2'd2
  } bot_state_e;

  localparam int unsigned SYNC_STAGES_DEF    = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000000;
  localparam int unsigned MISS_W_DEF         = 8;

endpackage

// File: rtl/mfp_sync_edge.sv
// Multi-flop synchronizer with rising-edge detector; reusable for any slow
// asynchronous level input such as the Rojobot strobe or push-buttons.
module mfp_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic evt_o
);

  logic [STAGES-1:0] sync_q;
  logic              sync_d_q;
  logic [STAGES:0]   prime_q;

  // prime_q masks the edge detector until the chain and its delay flop hold
  // real samples, so an input already high at reset release is not an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      sync_d_q <= 1'b0;
      prime_q  <= '0;
    end else begin
      sync_q   <= {sync_q[STAGES-2:0], d_i};
      sync_d_q <= sync_q[STAGES-1];
      prime_q  <= {prime_q[STAGES-1:0], 1'b1};
    end
  end

  assign evt_o = sync_q[STAGES-1] & ~sync_d_q & prime_q[STAGES];

endmodule

// File: rtl/mfp_bot_handshake.sv
// Rojobot-to-CPU update handshake: sticky update flag with info snapshot,
// one-deep newest-wins queue, overrun counting and acknowledge timeout.
module mfp_bot_handshake
  import mfp_bot_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned MISS_W         = MISS_W_DEF
) (
  input  logic              HCLK,
  input  logic              SI_Reset,
  input  logic              bot_upd_raw,
  input  logic [31:0]       bot_info_raw,
  input  logic              IO_INT_ACK,
  input  logic              clr_stats,
  output logic              IO_BotUpdt_Sync,
  output logic [31:0]       IO_BotInfo,
  output logic              upd_irq,
  output logic [MISS_W-1:0] miss_cnt,
  output logic              overrun,
  output logic              ack_timeout
);

  localparam int unsigned     TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_HIT = TMR_W'(TIMEOUT_CYCLES - 1);

  bot_state_e        state_q, state_d;
  logic              upd_evt;
  logic              present, miss_evt, timeout_evt;
  logic              q_vld_q, q_vld_d;
  logic [31:0]       q_info_q, q_info_d;
  logic [31:0]       info_q, info_d;
  logic              irq_q, irq_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              overrun_q, overrun_d;
  logic              ato_q, ato_d;

  mfp_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_i (HCLK),
    .rst_i (SI_Reset),
    .d_i   (bot_upd_raw),
    .evt_o (upd_evt)
  );

  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      state_q   <= IDLE;
      q_vld_q   <= 1'b0;
      info_q    <= '0;
      irq_q     <= 1'b0;
      timer_q   <= '0;
      miss_q    <= '0;
      overrun_q <= 1'b0;
      ato_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_vld_q   <= q_vld_d;
      info_q    <= info_d;
      irq_q     <= irq_d;
      timer_q   <= timer_d;
      miss_q    <= miss_d;
      overrun_q <= overrun_d;
      ato_q     <= ato_d;
    end
  end

  // Queue payload is only meaningful while q_vld_q is set.
  always_ff @(posedge HCLK) begin
    q_info_q <= q_info_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (upd_evt || q_vld_q) state_d = PENDING;
      PENDING: if (IO_INT_ACK)         state_d = ACKED;
      ACKED:   if (!IO_INT_ACK)        state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    present     = (state_q == IDLE) && (upd_evt || q_vld_q);
    miss_evt    = upd_evt && (state_q != IDLE) && q_vld_q;
    timeout_evt = (state_q == PENDING) && (timer_q == TMR_HIT);

    q_vld_d  = q_vld_q;
    q_info_d = q_info_q;
    info_d   = info_q;
    irq_d    = present;

    // An older queued update is presented first; a simultaneous new event
    // takes its place in the queue.
    if (present) begin
      info_d  = q_vld_q ? q_info_q : bot_info_raw;
      q_vld_d = upd_evt && q_vld_q;
      if (upd_evt && q_vld_q) q_info_d = bot_info_raw;
    end else if (upd_evt && (state_q != IDLE)) begin
      q_vld_d  = 1'b1;
      q_info_d = bot_info_raw;
    end

    if ((state_q == PENDING) && (state_d == PENDING))
      timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
    else
      timer_d = '0;

    if (miss_evt)
      miss_d = clr_stats ? MISS_W'(1) : ((miss_q == '1) ? miss_q : miss_q + 1'b1);
    else
      miss_d = clr_stats ? '0 : miss_q;

    overrun_d = miss_evt || (overrun_q && !clr_stats);
    ato_d     = timeout_evt || (ato_q && !clr_stats);
  end

  assign IO_BotUpdt_Sync = (state_q == PENDING);
  assign IO_BotInfo      = info_q;
  assign upd_irq         = irq_q;
  assign miss_cnt        = miss_q;
  assign overrun         = overrun_q;
  assign ack_timeout     = ato_q;

endmodule

// File: tb/tb_mfp_bot_handshake.sv
// Directed-vector bench for mfp_bot_handshake (SYNC_STAGES=2,
// TIMEOUT_CYCLES=16, MISS_W=2).
`timescale 1ns/1ps
module tb_mfp_bot_handshake;

  localparam int unsigned SYNC_STAGES    = 2;
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int unsigned MISS_W         = 2;

  logic              HCLK = 1'b0;
  logic              SI_Reset;
  logic              bot_upd_raw;
  logic [31:0]       bot_info_raw;
  logic              IO_INT_ACK;
  logic              clr_stats;
  logic              IO_BotUpdt_Sync;
  logic [31:0]       IO_BotInfo;
  logic              upd_irq;
  logic [MISS_W-1:0] miss_cnt;
  logic              overrun;
  logic              ack_timeout;

  int n_vec = 0;
  int n_err = 0;

  mfp_bot_handshake #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MISS_W         (MISS_W)
  ) dut (
    .HCLK            (HCLK),
    .SI_Reset        (SI_Reset),
    .bot_upd_raw     (bot_upd_raw),
    .bot_info_raw    (bot_info_raw),
    .IO_INT_ACK      (IO_INT_ACK),
    .clr_stats       (clr_stats),
    .IO_BotUpdt_Sync (IO_BotUpdt_Sync),
    .IO_BotInfo      (IO_BotInfo),
    .upd_irq         (upd_irq),
    .miss_cnt        (miss_cnt),
    .overrun         (overrun),
    .ack_timeout     (ack_timeout)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  // Strobe high 4 cycles, low 4; the event reaches the FSM on the 3rd edge.
  task automatic bot_update(input logic [31:0] info);
    bot_info_raw = info;
    bot_upd_raw  = 1'b1;
    tick(4);
    bot_upd_raw  = 1'b0;
    tick(4);
  endtask

  task automatic ack_cycle();
    IO_INT_ACK = 1'b1;
    tick();
    IO_INT_ACK = 1'b0;
    tick();
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
  endtask

  initial begin
    int bad;
    SI_Reset     = 1'b1;
    bot_upd_raw  = 1'b0;
    bot_info_raw = '0;
    IO_INT_ACK   = 1'b0;
    clr_stats    = 1'b0;
    tick(3);
    chk("rst_sync", {31'd0, IO_BotUpdt_Sync}, 32'd0);
    chk("rst_info", IO_BotInfo, 32'd0);
    chk("rst_irq",  {31'd0, upd_irq}, 32'd0);
    chk("rst_miss", {30'd0, miss_cnt}, 32'd0);
    chk("rst_ovr",  {31'd0, overrun}, 32'd0);
    chk("rst_ato",  {31'd0, ack_timeout}, 32'd0);
    SI_Reset = 1'b0;
    tick(5);

    // 1: basic handshake
    bot_info_raw = 32'h1234_5678;
    bot_upd_raw  = 1'b1;
    tick(2);
    chk("t1_sync_early", {31'd0, IO_BotUpdt_Sync}, 32'd0);
    tick();
    chk("t1_sync",  {31'd0, IO_BotUpdt_Sync}, 32'd1);
    chk("t1_info",  IO_BotInfo, 32'h1234_5678);
    chk("t1_irq",   {31'd0, upd_irq}, 32'd1);
    tick();
    chk("t1_irq_once", {31'd0, upd_irq}, 32'd0);
    tick();
    bot_upd_raw = 1'b0;
    tick(3);
    chk("t1_sync_held", {31'd0, IO_BotUpdt_Sync}, 32'd1);
    IO_INT_ACK = 1'b1;
    tick();
    chk("t1_ack_drop", {31'd0, IO_BotUpdt_Sync}, 32'd0);
    IO_INT_ACK = 1'b0;
    tick(2);
    chk("t1_idle_sync", {31'd0, IO_BotUpdt_Sync}, 32'd0);
    chk("t1_miss", {30'd0, miss_cnt}, 32'd0);

    // 2: one update queued while pending
    bot_update(32'hB000_0002);
    bot_update(32'hAAAA_0001);
    chk("t2_info_hold", IO_BotInfo, 32'hB000_0002);
    IO_INT_ACK = 1'b1;
    tick();
    chk("t2_acked", {31'd0, IO_BotUpdt_Sync}, 32'd0);
    IO_INT_ACK = 1'b0;
    tick();
    chk("t2_idle", {31'd0, IO_BotUpdt_Sync}, 32'd0);
    tick();
    chk("t2_resync", {31'd0, IO_BotUpdt_Sync}, 32'd1);
    chk("t2_info",   IO_BotInfo, 32'hAAAA_0001);
    chk("t2_irq",    {31'd0, upd_irq}, 32'd1);
    chk("t2_miss",   {30'd0, miss_cnt}, 32'd0);
    ack_cycle();
    tick();
    chk("t2_empty", {31'd0, IO_BotUpdt_Sync}, 32'd0);

    // 3: overwrite, newest wins
    bot_update(32'hB000_0003);
    bot_update(32'd1);
    bot_update(32'd2);
    bot_update(32'd3);
    chk("t3_miss", {30'd0, miss_cnt}, 32'd2);
    chk("t3_ovr",  {31'd0, overrun}, 32'd1);
    ack_cycle();
    tick();
    chk("t3_sync", {31'd0, IO_BotUpdt_Sync}, 32'd1);
    chk("t3_info", IO_BotInfo, 32'd3);
    pulse_clr();
    chk("t3_clr_miss", {30'd0, miss_cnt}, 32'd0);
    chk("t3_clr_ovr",  {31'd0, overrun}, 32'd0);
    ack_cycle();
    tick();
    chk("t3_empty", {31'd0, IO_BotUpdt_Sync}, 32'd0);

    // 4: acknowledge timeout
    pulse_clr();
    chk("t4_pre", {31'd0, ack_timeout}, 32'd0);
    bot_info_raw = 32'h4444_0004;
    bot_upd_raw  = 1'b1;
    tick(3);
    for (int i = 0; i < 15; i++) begin
      if (i == 2) bot_upd_raw = 1'b0;
      tick();
    end
    chk("t4_not_before", {31'd0, ack_timeout}, 32'd0);
    tick();
    chk("t4_set", {31'd0, ack_timeout}, 32'd1);
    ack_cycle();
    tick(2);
    chk("t4_sticky", {31'd0, ack_timeout}, 32'd1);
    pulse_clr();
    chk("t4_clr", {31'd0, ack_timeout}, 32'd0);

    // 5: saturation, ack + event together, clear beaten by a miss
    bot_update(32'hB000_0005);
    for (int i = 0; i < 6; i++) bot_update(32'h5000_0000 + i);
    chk("t5_sat", {30'd0, miss_cnt}, 32'd3);
    chk("t5_ovr", {31'd0, overrun}, 32'd1);
    bot_info_raw = 32'h5555_0005;
    bot_upd_raw  = 1'b1;
    tick(2);
    IO_INT_ACK = 1'b1;
    tick();
    chk("t5_simul_acked", {31'd0, IO_BotUpdt_Sync}, 32'd0);
    IO_INT_ACK  = 1'b0;
    bot_upd_raw = 1'b0;
    tick(2);
    chk("t5_simul_sync", {31'd0, IO_BotUpdt_Sync}, 32'd1);
    chk("t5_simul_info", IO_BotInfo, 32'h5555_0005);
    bot_update(32'h6666_0006);
    bot_info_raw = 32'h7777_0007;
    bot_upd_raw  = 1'b1;
    tick(2);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("t5_clr_miss", {30'd0, miss_cnt}, 32'd1);
    chk("t5_clr_ovr",  {31'd0, overrun}, 32'd1);
    tick(3);

    // 6: async reset while pending with a queued entry, strobe held high
    @(posedge HCLK);
    #1 SI_Reset = 1'b1;
    #2;
    chk("t6_sync", {31'd0, IO_BotUpdt_Sync}, 32'd0);
    chk("t6_info", IO_BotInfo, 32'd0);
    chk("t6_miss", {30'd0, miss_cnt}, 32'd0);
    chk("t6_ovr",  {31'd0, overrun}, 32'd0);
    chk("t6_ato",  {31'd0, ack_timeout}, 32'd0);
    chk("t6_irq",  {31'd0, upd_irq}, 32'd0);
    tick(2);
    SI_Reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (IO_BotUpdt_Sync || upd_irq) bad++;
    end
    chk("t6_no_spurious", bad, 0);
    bot_upd_raw = 1'b0;
    tick(4);
    bot_update(32'h8888_0008);
    chk("t6_new_info", IO_BotInfo, 32'h8888_0008);
    ack_cycle();
    tick();
    chk("t6_queue_cleared", {31'd0, IO_BotUpdt_Sync}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
